z80_bus_ctrl: RTL
=================

Name: z80_bus_ctrl

Overview:
Memory/IO bus controller that sits directly downstream of z80cpu and replaces the behavioural ROM/RAM/print glue around the core with synthesisable logic. Decodes core strobes (including their _z tri-state flags), steers accesses to a combinational ROM port or a 1-cycle-latency synchronous RAM port, and inserts WAIT states. Captures memory writes to the print address into a FIFO for a downstream character sink. Runs entirely on MCLK, the same domain as the core, so no synchronisers are needed.

Parameters:
ROM_TOP, 16'h4000, addresses below this go to ROM; addresses at or above go to RAM
PRINT_ADDR, 16'h1234, memory-write address captured into the print FIFO
WAIT_MCLK, 0, extra MCLK cycles WAIT is held low after RAM data is ready (0 = none)
FIFO_DEPTH, 16, print FIFO entries (power of 2, >= 2)

Ports:
MCLK  in  1  master clock, same clock as z80cpu MCLK
RESET  in  1  asynchronous, active-high reset
ADDRESS  in  16  core address
ADDRESS_z  in  1  address bus floated
DATA_o  in  8  core write data
DATA_z  in  1  core data bus floated
MREQ, IORQ, RD, WR, RFSH, M1  in  1 each  core strobes, active-low
MREQ_z, IORQ_z, RD_z, WR_z  in  1 each  strobe floated flags
DATA_i  out  8  read data to core
WAIT  out  1  active-low wait to core
rom_addr  out  14  ROM address
rom_data  in  8  ROM data, combinational
ram_addr  out  16  RAM address
ram_wdata  out  8  RAM write data
ram_we  out  1  RAM write strobe, one MCLK pulse
ram_re  out  1  RAM read strobe, one MCLK pulse
ram_rdata  in  8  RAM data, valid on the MCLK after ram_re
pr_data  out  8  FIFO head byte
pr_valid  out  1  FIFO not empty
pr_ready  in  1  sink pop; pop occurs on pr_valid & pr_ready
pr_ovf  out  1  sticky overflow flag

Behaviour:
- Qualified strobes: mrd = !MREQ & !MREQ_z & !RD & !RD_z & RFSH; mwr = the same with WR/WR_z; iord = !IORQ & !IORQ_z & !RD & !RD_z. If ADDRESS_z is set, all three are forced to 0.
- Reset values: WAIT=1, DATA_i=8'hFF, ram_we=0, ram_re=0, pr_valid=0, pr_ovf=0, FIFO empty, FSM in IDLE.
- FSM states: IDLE, RD_ISSUE, RD_LATCH, WAITCNT, HOLD.
- IDLE:
  - Rising edge of mrd with ADDRESS >= ROM_TOP: go to RD_ISSUE; WAIT drops low in the same cycle the edge is registered.
  - Rising edge of mrd with ADDRESS < ROM_TOP: DATA_i = rom_data combinationally while mrd is active; go to HOLD; WAIT stays 1.
- RD_ISSUE: ram_re=1, ram_addr=ADDRESS; go to RD_LATCH.
- RD_LATCH: latch ram_rdata into the read register. Go to WAITCNT if WAIT_MCLK > 0, else HOLD.
- WAITCNT: count WAIT_MCLK cycles, then go to HOLD.
- WAIT returns to 1 on entry to HOLD.
- HOLD: DATA_i = latched byte while mrd is active; return to IDLE when mrd, mwr and iord are all 0.
- iord: DATA_i = ADDRESS[0] ? 8'hFF : 8'hBF. No FSM involvement, no wait.
- DATA_i = 8'hFF whenever no read is active.
- Writes, on the rising edge of mwr (registered, one cycle later):
  - If ADDRESS >= ROM_TOP: ram_we pulses for 1 MCLK with ram_addr and ram_wdata = DATA_o sampled at the edge.
  - If ADDRESS < ROM_TOP: the write is dropped silently.
  - If ADDRESS == PRINT_ADDR: additionally push DATA_o into the FIFO, independent of the RAM/ROM decision.
- FIFO:
  - Push and pop in the same cycle: count is unchanged; when empty, the pushed byte becomes the head.
  - Push when full: data is dropped and pr_ovf is set; pr_ovf clears only on RESET.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- A refresh cycle (RFSH low) never starts an access and never disturbs the FSM.
- Strobes dropping during RD_ISSUE, RD_LATCH or WAITCNT: the sequence completes, then the FSM passes through HOLD to IDLE.
- RESET asserted mid-access: immediate return to reset values. A RAM write in flight is abandoned; no ram_we is issued after reset.

Decomposition:
- Package z80_bus_pkg holds:
  - bus_state_t enum (IDLE, RD_ISSUE, RD_LATCH, WAITCNT, HOLD)
  - constant IO_RD_ODD = 8'hFF
  - constant IO_RD_EVEN = 8'hBF
  - constant BUS_IDLE_DATA = 8'hFF
- One sub-module: z80_print_fifo (parameterised by FIFO_DEPTH; push/pop/full/empty/overflow).

Test Plan:
- RESET high mid-sequence -> WAIT=1, DATA_i=FF, pr_valid=0 immediately. Release, fetch from 0x0000 with rom_data=31 -> DATA_i=31, WAIT never low.
- mrd at 0x8000, ram_rdata=A5, WAIT_MCLK=0 -> ram_re exactly 1 cycle; WAIT low 2 MCLK; DATA_i=A5 until RD rises.
- Same access with WAIT_MCLK=3 -> WAIT low 5 MCLK, then DATA_i=A5.
- Write 0x41 to 0x1234, pr_ready=0 -> no ram_we; pr_valid=1, pr_data=41. Write 0x55 to 0x9000 -> ram_we one pulse, ram_addr=9000, ram_wdata=55.
- 17 writes to 0x1234 with FIFO_DEPTH=16 and pr_ready=0 -> pr_ovf=1, 16 bytes retained in order. Pop all -> bytes 0..15 returned, pr_valid=0; push+pop in the same cycle keeps count.
- IO read at 0x00FE -> DATA_i=BF; at 0x00FF -> FF. Refresh cycle with MREQ low, RFSH low -> no ram_re/ram_we, FSM stays IDLE.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the z80 memory/IO bus controller.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_LATCH,
        WAITCNT,
        HOLD
    } bus_state_t;

    localparam logic [7:0] IO_RD_ODD     = 8'hFF;
    localparam logic [7:0] IO_RD_EVEN    = 8'hBF;
    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

endpackage

// File: rtl/z80_print_fifo.sv
// Byte FIFO between the print-address write capture and the character sink.
module z80_print_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_req,
    output logic [7:0] head,
    output logic       empty,
    output logic       ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = pop_req & !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (!full | pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: ROM/RAM steering, WAIT insertion, IO read stub and
// print-address capture into a FIFO, all on MCLK.
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] ROM_TOP    = 16'h4000,
    parameter logic [15:0] PRINT_ADDR = 16'h1234,
    parameter int          WAIT_MCLK  = 0,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [15:0] ADDRESS,
    input  logic        ADDRESS_z,
    input  logic [7:0]  DATA_o,
    input  logic        DATA_z,
    input  logic        MREQ,
    input  logic        IORQ,
    input  logic        RD,
    input  logic        WR,
    input  logic        RFSH,
    input  logic        M1,
    input  logic        MREQ_z,
    input  logic        IORQ_z,
    input  logic        RD_z,
    input  logic        WR_z,
    output logic [7:0]  DATA_i,
    output logic        WAIT,
    output logic [13:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  pr_data,
    output logic        pr_valid,
    input  logic        pr_ready,
    output logic        pr_ovf
);

    localparam int CNT_W = (WAIT_MCLK > 1) ? $clog2(WAIT_MCLK) : 1;

    bus_state_t       state;
    bus_state_t       state_nxt;
    logic             mrd, mwr, iord;
    logic             mrd_p1, mwr_p1;
    logic             mrd_rise, mwr_rise;
    logic             is_ram;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rd_byte;
    logic [15:0]      wr_addr_p1;
    logic [7:0]       wr_data_p1;
    logic             push_p1;
    logic             fifo_empty;
    logic             unused_inputs;

    // M1 and the data-bus float flag carry nothing the decode needs.
    assign unused_inputs = &{1'b0, DATA_z, M1};

    assign mrd  = !ADDRESS_z && !MREQ && !MREQ_z && !RD && !RD_z && RFSH;
    assign mwr  = !ADDRESS_z && !MREQ && !MREQ_z && !WR && !WR_z && RFSH;
    assign iord = !ADDRESS_z && !IORQ && !IORQ_z && !RD && !RD_z;

    assign is_ram   = (ADDRESS >= ROM_TOP);
    assign mrd_rise = mrd && !mrd_p1;
    assign mwr_rise = mwr && !mwr_p1;

    // Edge detectors reset to 1 so a strobe still held across reset release
    // is not mistaken for a fresh access.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            mrd_p1  <= 1'b1;
            mwr_p1  <= 1'b1;
            ram_we  <= 1'b0;
            push_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            mrd_p1  <= mrd;
            mwr_p1  <= mwr;
            ram_we  <= mwr_rise && is_ram;
            push_p1 <= mwr_rise && (ADDRESS == PRINT_ADDR);
        end
    end

    always_ff @(posedge MCLK) begin
        if (mwr_rise) begin
            wr_addr_p1 <= ADDRESS;
            wr_data_p1 <= DATA_o;
        end
        if (state == RD_LATCH) begin
            rd_byte <= ram_rdata;
            cnt     <= CNT_W'(WAIT_MCLK - 1);
        end else if (state == WAITCNT) begin
            cnt     <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        WAIT      = 1'b1;
        case (state)
            IDLE: begin
                if (mrd_rise) state_nxt = is_ram ? RD_ISSUE : HOLD;
            end
            RD_ISSUE: begin
                ram_re    = 1'b1;
                WAIT      = 1'b0;
                state_nxt = RD_LATCH;
            end
            RD_LATCH: begin
                WAIT      = 1'b0;
                state_nxt = (WAIT_MCLK > 0) ? WAITCNT : HOLD;
            end
            WAITCNT: begin
                WAIT = 1'b0;
                if (cnt == '0) state_nxt = HOLD;
            end
            HOLD: begin
                if (!mrd && !mwr && !iord) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DATA_i = BUS_IDLE_DATA;
        if (iord)                     DATA_i = ADDRESS[0] ? IO_RD_ODD : IO_RD_EVEN;
        else if (mrd && !is_ram)      DATA_i = rom_data;
        else if (mrd && state == HOLD) DATA_i = rd_byte;
    end

    assign rom_addr  = ADDRESS[13:0];
    assign ram_addr  = ram_we ? wr_addr_p1 : ADDRESS;
    assign ram_wdata = wr_data_p1;
    assign pr_valid  = !fifo_empty;

    z80_print_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (MCLK),
        .rst       (RESET),
        .push      (push_p1),
        .push_data (wr_data_p1),
        .pop_req   (pr_ready),
        .head      (pr_data),
        .empty     (fifo_empty),
        .ovf       (pr_ovf)
    );

endmodule
